// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM stage: wait-stated data RAM access feeding the MEM/WB register
module mem_access_stage #(
    parameter int DEPTH       = 256,
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic [31:0] aludata_in,
    input  logic [31:0] wdata_in,
    input  logic [4:0]  wrreg_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic        MemtoReg_in,
    input  logic        RegWrite_in,
    input  logic [1:0]  size_in,
    input  logic        unsigned_in,
    input  logic [2:0]  INS_ID_in,
    output logic        stall,
    output logic [31:0] memdata_out,
    output logic [31:0] aludata_out,
    output logic [4:0]  wrreg_out,
    output logic        MemtoReg_out,
    output logic        RegWrite_out,
    output logic [2:0]  INS_ID_out,
    output logic        misalign_out
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               access;

    logic [31:0]        mem [DEPTH];
    logic [ADDR_W-1:0]  word_idx;
    logic [31:0]        rd_word;
    logic               mem_op, misaligned, mem_go, is_load;
    logic [7:0]         ld_byte;
    logic [15:0]        ld_half;
    logic [31:0]        ld_ext, load_data;
    logic [3:0]         wr_mask;
    logic [31:0]        wr_word;

    assign word_idx = aludata_in[ADDR_W+1:2];
    assign rd_word  = mem[word_idx];
    assign mem_op   = valid_in & (MemRead_in | MemWrite_in);
    assign is_load  = MemRead_in & ~MemWrite_in;

    always_comb begin
        misaligned = 1'b0;
        if (size_in == 2'b01)
            misaligned = aludata_in[0];
        else if (size_in[1])
            misaligned = |aludata_in[1:0];
    end

    assign mem_go = mem_op & ~misaligned;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall     = 1'b0;
        access    = 1'b0;
        case (state)
            IDLE: begin
                if (mem_go) begin
                    if (WAIT_STATES == 0) begin
                        access = 1'b1;
                    end else begin
                        stall = 1'b1;
                        if (WAIT_STATES == 1) begin
                            state_nxt = DONE;
                        end else begin
                            state_nxt = WAIT;
                            cnt_nxt   = CNT_INIT;
                        end
                    end
                end
            end
            WAIT: begin
                stall   = 1'b1;
                cnt_nxt = cnt - CNT_ONE;
                if (cnt == CNT_ONE)
                    state_nxt = DONE;
            end
            DONE: begin
                access    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Load path: pick the lane, shift to bit 0, then extend
    always_comb begin
        case (aludata_in[1:0])
            2'd0:    ld_byte = rd_word[7:0];
            2'd1:    ld_byte = rd_word[15:8];
            2'd2:    ld_byte = rd_word[23:16];
            default: ld_byte = rd_word[31:24];
        endcase
        ld_half = aludata_in[1] ? rd_word[31:16] : rd_word[15:0];
        case (size_in)
            2'b00:   ld_ext = unsigned_in ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   ld_ext = unsigned_in ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_ext = rd_word;
        endcase
        load_data = (valid_in && is_load && !misaligned) ? ld_ext : 32'b0;
    end

    always_comb begin
        case (size_in)
            2'b00: begin
                wr_mask = 4'b0001 << aludata_in[1:0];
                wr_word = {4{wdata_in[7:0]}};
            end
            2'b01: begin
                wr_mask = aludata_in[1] ? 4'b1100 : 4'b0011;
                wr_word = {2{wdata_in[15:0]}};
            end
            default: begin
                wr_mask = 4'b1111;
                wr_word = wdata_in;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n && access && MemWrite_in) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_mask[i])
                    mem[word_idx][i*8 +: 8] <= wr_word[i*8 +: 8];
            end
        end
    end

    // While stalled, push bubbles so MEM/WB never captures the same op twice
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            memdata_out  <= 32'b0;
            aludata_out  <= 32'b0;
            wrreg_out    <= 5'b0;
            MemtoReg_out <= 1'b0;
            RegWrite_out <= 1'b0;
            INS_ID_out   <= 3'b0;
            misalign_out <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (stall) begin
                MemtoReg_out <= 1'b0;
                RegWrite_out <= 1'b0;
                misalign_out <= 1'b0;
            end else begin
                memdata_out  <= load_data;
                aludata_out  <= aludata_in;
                wrreg_out    <= wrreg_in;
                MemtoReg_out <= valid_in & MemtoReg_in;
                RegWrite_out <= valid_in & RegWrite_in & ~(mem_op & misaligned);
                INS_ID_out   <= INS_ID_in;
                misalign_out <= mem_op & misaligned;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - scoreboard bench for mem_access_stage (2 wait states and 0 wait states)
module tb_mem_access_stage;

    localparam int WS_A = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_a, valid_b;
    logic [31:0] aludata, wdata;
    logic [4:0]  wrreg;
    logic        mem_read, mem_write, memtoreg, regwrite, unsgn;
    logic [1:0]  size;
    logic [2:0]  ins_id;

    logic        stall_a, memtoreg_a, regwrite_a, misalign_a;
    logic [31:0] memdata_a, aludata_a;
    logic [4:0]  wrreg_a;
    logic [2:0]  ins_id_a;
    logic        stall_b, memtoreg_b, regwrite_b, misalign_b;
    logic [31:0] memdata_b, aludata_b;
    logic [4:0]  wrreg_b;
    logic [2:0]  ins_id_b;

    always #5 clk = ~clk;

    mem_access_stage #(.DEPTH(256), .ADDR_W(8), .WAIT_STATES(WS_A)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_a), .aludata_in(aludata), .wdata_in(wdata),
        .wrreg_in(wrreg), .MemRead_in(mem_read), .MemWrite_in(mem_write), .MemtoReg_in(memtoreg),
        .RegWrite_in(regwrite), .size_in(size), .unsigned_in(unsgn), .INS_ID_in(ins_id),
        .stall(stall_a), .memdata_out(memdata_a), .aludata_out(aludata_a), .wrreg_out(wrreg_a),
        .MemtoReg_out(memtoreg_a), .RegWrite_out(regwrite_a), .INS_ID_out(ins_id_a),
        .misalign_out(misalign_a)
    );

    mem_access_stage #(.DEPTH(256), .ADDR_W(8), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_b), .aludata_in(aludata), .wdata_in(wdata),
        .wrreg_in(wrreg), .MemRead_in(mem_read), .MemWrite_in(mem_write), .MemtoReg_in(memtoreg),
        .RegWrite_in(regwrite), .size_in(size), .unsigned_in(unsgn), .INS_ID_in(ins_id),
        .stall(stall_b), .memdata_out(memdata_b), .aludata_out(aludata_b), .wrreg_out(wrreg_b),
        .MemtoReg_out(memtoreg_b), .RegWrite_out(regwrite_b), .INS_ID_out(ins_id_b),
        .misalign_out(misalign_b)
    );

    typedef struct {
        logic [31:0] memdata;
        logic [31:0] aludata;
        logic [4:0]  wrreg;
        logic        memtoreg;
        logic        regwrite;
        logic [2:0]  ins_id;
        logic        misalign;
        int          stalls;
    } exp_t;

    exp_t       sb[$];
    int         n_assert = 0;
    int         n_fail = 0;
    int         b_stall_seen = 0;
    logic [2:0] tag = 3'd0;

    always @(posedge clk) if (stall_b === 1'b1) b_stall_seen++;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic sample(input bit sel, output exp_t o);
        if (!sel) begin
            o.memdata = memdata_a; o.aludata = aludata_a; o.wrreg = wrreg_a;
            o.memtoreg = memtoreg_a; o.regwrite = regwrite_a; o.ins_id = ins_id_a;
            o.misalign = misalign_a;
        end else begin
            o.memdata = memdata_b; o.aludata = aludata_b; o.wrreg = wrreg_b;
            o.memtoreg = memtoreg_b; o.regwrite = regwrite_b; o.ins_id = ins_id_b;
            o.misalign = misalign_b;
        end
        o.stalls = 0;
    endtask

    task automatic op(input bit sel, input logic v, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [4:0] rd, input logic rdm, input logic wrm, input logic m2r,
                      input logic rw, input logic [1:0] sz, input logic us,
                      input logic [31:0] exp_mem, input logic exp_mis, input int exp_stalls);
        exp_t e, o;
        int   stalls;
        tag = tag + 3'd1;
        valid_a = sel ? 1'b0 : v;
        valid_b = sel ? v : 1'b0;
        aludata = addr; wdata = wd; wrreg = rd; mem_read = rdm; mem_write = wrm;
        memtoreg = m2r; regwrite = rw; size = sz; unsgn = us; ins_id = tag;
        e.memdata = exp_mem; e.aludata = addr; e.wrreg = rd; e.memtoreg = v & m2r;
        e.regwrite = v & rw & ~exp_mis; e.ins_id = tag; e.misalign = exp_mis; e.stalls = exp_stalls;
        sb.push_back(e);
        stalls = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((sel ? stall_b : stall_a) !== 1'b1) break;
            stalls++;
            @(posedge clk); #1;
            sample(sel, o);
            chk("bubble_regwrite", {31'b0, o.regwrite}, 32'd0);
            chk("bubble_memtoreg", {31'b0, o.memtoreg}, 32'd0);
        end
        @(posedge clk); #1;
        sample(sel, o);
        e = sb.pop_front();
        chk("stall_cycles", 32'(stalls), 32'(e.stalls));
        chk("memdata", o.memdata, e.memdata);
        chk("aludata", o.aludata, e.aludata);
        chk("wrreg", {27'b0, o.wrreg}, {27'b0, e.wrreg});
        chk("memtoreg", {31'b0, o.memtoreg}, {31'b0, e.memtoreg});
        chk("regwrite", {31'b0, o.regwrite}, {31'b0, e.regwrite});
        chk("ins_id", {29'b0, o.ins_id}, {29'b0, e.ins_id});
        chk("misalign", {31'b0, o.misalign}, {31'b0, e.misalign});
    endtask

    task automatic sw(input bit sel, input logic [31:0] addr, input logic [31:0] d,
                      input logic [1:0] sz, input logic mis);
        op(sel, 1'b1, addr, d, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, sz, 1'b0, 32'd0, mis,
           (mis || sel) ? 0 : WS_A);
    endtask

    task automatic ld(input bit sel, input logic [31:0] addr, input logic [1:0] sz,
                      input logic us, input logic [31:0] exp, input logic mis);
        op(sel, 1'b1, addr, 32'd0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, sz, us, exp, mis,
           (mis || sel) ? 0 : WS_A);
    endtask

    initial begin
        exp_t o;
        rst_n = 1'b0; valid_a = 1'b0; valid_b = 1'b0; aludata = 32'd0; wdata = 32'd0;
        wrreg = 5'd0; mem_read = 1'b0; mem_write = 1'b0; memtoreg = 1'b0; regwrite = 1'b0;
        size = 2'b00; unsgn = 1'b0; ins_id = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        sample(1'b0, o);
        chk("rst_memdata", o.memdata, 32'd0);
        chk("rst_aludata", o.aludata, 32'd0);
        chk("rst_regwrite", {31'b0, o.regwrite}, 32'd0);
        chk("rst_stall", {31'b0, stall_a}, 32'd0);
        rst_n = 1'b1;

        sw(1'b0, 32'h10, 32'h0, 2'b10, 1'b0);

        // Store aborted by reset while waiting
        tag = tag + 3'd1;
        valid_a = 1'b1; aludata = 32'h10; wdata = 32'hDEADBEEF; wrreg = 5'd2;
        mem_read = 1'b0; mem_write = 1'b1; size = 2'b10; ins_id = tag;
        @(negedge clk);
        chk("abort_stall_pre", {31'b0, stall_a}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0; valid_a = 1'b0;
        @(posedge clk); #1;
        sample(1'b0, o);
        chk("abort_memdata", o.memdata, 32'd0);
        chk("abort_aludata", o.aludata, 32'd0);
        chk("abort_wrreg", {27'b0, o.wrreg}, 32'd0);
        chk("abort_ins_id", {29'b0, o.ins_id}, 32'd0);
        chk("abort_misalign", {31'b0, o.misalign}, 32'd0);
        chk("abort_stall", {31'b0, stall_a}, 32'd0);
        rst_n = 1'b1;
        ld(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 1'b0);

        sw(1'b0, 32'h20, 32'h12345678, 2'b10, 1'b0);
        ld(1'b0, 32'h20, 2'b10, 1'b0, 32'h12345678, 1'b0);
        ld(1'b0, 32'h23, 2'b00, 1'b0, 32'h00000012, 1'b0);
        sw(1'b0, 32'h21, 32'hFFFFFF80, 2'b00, 1'b0);
        ld(1'b0, 32'h21, 2'b00, 1'b0, 32'hFFFFFF80, 1'b0);
        ld(1'b0, 32'h21, 2'b00, 1'b1, 32'h00000080, 1'b0);
        ld(1'b0, 32'h22, 2'b01, 1'b0, 32'h00001234, 1'b0);
        ld(1'b0, 32'h20, 2'b01, 1'b0, 32'hFFFF8078, 1'b0);

        ld(1'b0, 32'h22, 2'b10, 1'b0, 32'h0, 1'b1);
        sw(1'b0, 32'h21, 32'h0000FFFF, 2'b01, 1'b1);
        ld(1'b0, 32'h20, 2'b10, 1'b0, 32'h12348078, 1'b0);

        op(1'b0, 1'b1, 32'h55, 32'd0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'd0, 1'b0, 0);
        op(1'b0, 1'b0, 32'h66, 32'd0, 5'd8, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 32'd0, 1'b0, 0);

        op(1'b0, 1'b1, 32'h30, 32'hA5A5A5A5, 5'd4, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0,
           32'd0, 1'b0, WS_A);
        ld(1'b0, 32'h30, 2'b10, 1'b0, 32'hA5A5A5A5, 1'b0);

        sw(1'b1, 32'h400, 32'h11223344, 2'b10, 1'b0);
        ld(1'b1, 32'h000, 2'b10, 1'b0, 32'h11223344, 1'b0);
        sw(1'b1, 32'h402, 32'h0000BEEF, 2'b01, 1'b0);
        ld(1'b1, 32'h002, 2'b01, 1'b1, 32'h0000BEEF, 1'b0);
        ld(1'b1, 32'h403, 2'b00, 1'b0, 32'hFFFFFFBE, 1'b0);
        ld(1'b1, 32'h000, 2'b10, 1'b0, 32'hBEEF3344, 1'b0);
        chk("ws0_never_stalled", 32'(b_stall_seen), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
